// File: rtl/shr_drv_pkg.sv
// shr_drv_pkg: shared state encoding and sizing helper for the serial
// harness host driver (shr_host_driver and its shifter).
package shr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    STB1,
    GAP,
    STB2,
    SHIFT_OUT,
    DONE
  } state_t;

  // Width of a counter that must be able to hold the value n (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shr_drv_shifter.sv
// shr_drv_shifter: W-bit shift register with parallel load, shift enable,
// serial input at the LSB end and serial output from the MSB. Used as the
// PISO for stimulus and the SIPO for the response.
module shr_drv_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  input  logic         ser_in,
  output logic [W-1:0] data,
  output logic         ser_out
);

  logic [W-1:0] shifted;

  if (W == 1) begin : g_one
    assign shifted = ser_in;
  end else begin : g_wide
    assign shifted = {data[W-2:0], ser_in};
  end

  assign ser_out = data[W-1];

  // Parallel load wins over shift; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= shifted;
    end
  end

endmodule

// File: rtl/shr_host_driver.sv
// shr_host_driver: host-side end of the minitest serial harness.
// Shifts a DIN_N-bit stimulus out on di (MSB first), pulses stb twice so the
// harness first latches din and then captures the roi response, shifts the
// DOUT_N-bit response back in from do_i (MSB first) and returns it over a
// valid/ready port. One vector is in flight at a time.
// Build macro SHR_DRV_SETTLE_EN: stretches the gap between the two strobes
// by SETTLE_CYCLES extra cycles for deep roi combinational paths.
module shr_host_driver
  import shr_drv_pkg::*;
#(
  parameter int DIN_N         = 256,
  parameter int DOUT_N        = 256,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DIN_N-1:0]  tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DOUT_N-1:0] rx_data,
  output logic              di,
  output logic              stb,
  input  logic              do_i,
  output logic              busy
);

  localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int CW    = cnt_w(MAX_N);
  localparam logic [CW-1:0] DIN_LAST  = CW'(DIN_N - 1);
  localparam logic [CW-1:0] DOUT_LAST = CW'(DOUT_N - 1);

  if (DIN_N < 1 || DOUT_N < 1 || SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_params
    $error("shr_host_driver: DIN_N/DOUT_N must be >= 1 and SETTLE_CYCLES in 0..255");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            tx_load;
  logic            tx_shift;
  logic            rx_shift;
  logic [DIN_N-1:0] unused_tx_word;
  logic            unused_rx_msb;

`ifdef SHR_DRV_SETTLE_EN
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  logic [7:0] settle_cnt;
`endif

  assign tx_load  = (state == IDLE) && tx_valid && tx_ready;
  assign tx_shift = (state == SHIFT_IN);
  assign rx_shift = (state == SHIFT_OUT);

  // The stimulus register shifts zeros in behind the data, so once the
  // vector has gone out its MSB is 0 and di can come straight off the flop.
  shr_drv_shifter #(.W(DIN_N)) u_tx_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .shift     (tx_shift),
    .load_data (tx_data),
    .ser_in    (1'b0),
    .data      (unused_tx_word),
    .ser_out   (di)
  );

  // Response capture; its register is the rx_data output and holds still
  // outside SHIFT_OUT.
  shr_drv_shifter #(.W(DOUT_N)) u_rx_sipo (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .shift     (rx_shift),
    .load_data ({DOUT_N{1'b0}}),
    .ser_in    (do_i),
    .data      (rx_data),
    .ser_out   (unused_rx_msb)
  );

  // Sequencer: walks the harness protocol and drives stb, tx_ready, rx_valid
  // and busy as registers so none of them can glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      stb      <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef SHR_DRV_SETTLE_EN
      settle_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= SHIFT_IN;
            cnt      <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT_IN: begin
          if (cnt == DIN_LAST) begin
            state <= STB1;
            cnt   <= '0;
            stb   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STB1: begin
          state <= GAP;
          stb   <= 1'b0;
`ifdef SHR_DRV_SETTLE_EN
          settle_cnt <= '0;
`endif
        end
        GAP: begin
`ifdef SHR_DRV_SETTLE_EN
          if (settle_cnt == SETTLE_LAST) begin
            state <= STB2;
            stb   <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
`else
          state <= STB2;
          stb   <= 1'b1;
`endif
        end
        STB2: begin
          state <= SHIFT_OUT;
          stb   <= 1'b0;
          cnt   <= '0;
        end
        SHIFT_OUT: begin
          if (cnt == DOUT_LAST) begin
            state    <= DONE;
            cnt      <= '0;
            rx_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rx_ready) begin
            state    <= IDLE;
            rx_valid <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          stb      <= 1'b0;
          tx_ready <= 1'b1;
          rx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shr_host_driver.sv
// tb_shr_host_driver: self-checking bench for shr_host_driver with a cycle
// model of the minitest harness (roi = bitwise invert). Expected responses
// and acceptance edges are queued when a vector is accepted; a monitor pops
// and compares on every rx handshake and checks latency on rx_valid rise.
// Build macro SHR_DRV_SETTLE_EN selects the stretched strobe gap.
module tb_shr_host_driver;

  localparam int DIN_N  = 8;
  localparam int DOUT_N = 8;
  localparam int SETTLE_PARAM = 4;
`ifdef SHR_DRV_SETTLE_EN
  localparam int SETTLE = SETTLE_PARAM;
`else
  localparam int SETTLE = 0;
`endif
  localparam int LAT    = DIN_N + DOUT_N + 3 + SETTLE;
  localparam int STB2_N = DIN_N + 2 + SETTLE;

  logic              clk;
  logic              rst_n;
  logic              tx_valid;
  logic              tx_ready;
  logic [DIN_N-1:0]  tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DOUT_N-1:0] rx_data;
  logic              di;
  logic              stb;
  logic              do_i;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = -100;
  logic prev_rv = 1'b0;
  logic [DOUT_N-1:0] exp_q[$];
  int                lat_q[$];

  shr_host_driver #(
    .DIN_N         (DIN_N),
    .DOUT_N        (DOUT_N),
    .SETTLE_CYCLES (SETTLE_PARAM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .di       (di),
    .stb      (stb),
    .do_i     (do_i),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a negedge, cyc is the index of the most recent posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Harness model: shift din/dout while stb is low; on stb latch din and
  // load dout with roi of the previously latched din.
  logic [DIN_N-1:0]  h_din_shr = '0;
  logic [DIN_N-1:0]  h_din_lat = '0;
  logic [DOUT_N-1:0] h_dout_shr = '0;
  always @(posedge clk) begin
    if (stb) begin
      h_din_lat  <= h_din_shr;
      h_dout_shr <= ~h_din_lat;
    end else begin
      h_din_shr  <= {h_din_shr[DIN_N-2:0], di};
      h_dout_shr <= {h_dout_shr[DOUT_N-2:0], 1'b0};
    end
  end
  assign do_i = h_dout_shr[DOUT_N-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at edge %0d", name, cyc);
  endtask

  // Offer a vector and wait for acceptance; the reference response (roi =
  // invert) and the accept edge go onto the scoreboard.
  task automatic applyStimulus(input logic [DIN_N-1:0] v, input bit keep, output int acc_edge);
    bit done;
    done = 1'b0;
    acc_edge = -1;
    tx_data  = v;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        acc_edge = cyc + 1;
        exp_q.push_back(~v);
        lat_q.push_back(cyc + 1);
        done = 1'b1;
      end
    end
    if (!done) failNow("accept_timeout");
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  // Wait until the scoreboard has drained, then step past the handshake edge.
  task automatic waitDone();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) failNow("response_timeout");
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on rx_valid rise, data on each rx handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (rx_valid && !prev_rv) begin
        if (lat_q.size() == 0) failNow("latency_unexpected_valid");
        else checkOutput("latency", 64'(cyc - lat_q[0]), 64'(LAT));
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          failNow("rx_unexpected");
        end else begin
          checkOutput("rx_data", 64'(rx_data), 64'(exp_q.pop_front()));
          lat_q.delete(0);
        end
        last_hs = cyc + 1;
      end
      prev_rv = rx_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0;
    int a1;
    int a2;
    int d;
    bit seen;
    logic [DIN_N-1:0] vec;

    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", 64'(rx_data), 64'd0);
    checkOutput("reset_tx_ready", 64'(tx_ready), 64'd1);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_tx_ready", 64'(tx_ready), 64'd1);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_di", 64'(di), 64'd0);
      checkOutput("idle_stb", 64'(stb), 64'd0);
      checkOutput("idle_rx_valid", 64'(rx_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Single vector with serial timing, then back-pressure
    $display("[TB] single vector 0xA5 with back-pressure");
    vec = 8'hA5;
    rx_ready = 1'b0;
    applyStimulus(vec, 1'b0, a0);
    for (int n = 0; n <= STB2_N + 1; n++) begin
      @(negedge clk);
      checkOutput("di_seq", 64'(di), (n < DIN_N) ? 64'(vec[DIN_N-1-n]) : 64'd0);
      checkOutput("stb_seq", 64'(stb), (n == DIN_N || n == STB2_N) ? 64'd1 : 64'd0);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rx_valid) seen = 1'b1;
    end
    if (!seen) failNow("rx_valid_timeout");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("bp_rx_data", 64'(rx_data), 64'h5A);
      checkOutput("bp_rx_valid", 64'(rx_valid), 64'd1);
      checkOutput("bp_tx_ready", 64'(tx_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    waitDone();
    @(negedge clk);
    checkOutput("release_tx_ready", 64'(tx_ready), 64'd1);
    checkOutput("release_busy", 64'(busy), 64'd0);
    checkOutput("release_rx_valid", 64'(rx_valid), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back with tx_valid held across both vectors
    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(8'h00, 1'b1, a1);
    applyStimulus(8'hFF, 1'b0, a2);
    checkOutput("b2b_accept_edge", 64'(a2), 64'(last_hs + 1));
    waitDone();

    // Reset in the middle of SHIFT_IN
    $display("[TB] reset during shift-in");
    applyStimulus(8'h77, 1'b0, a0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx_ready", 64'(tx_ready), 64'd1);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_di", 64'(di), 64'd0);
    checkOutput("mid_rst_stb", 64'(stb), 64'd0);
    checkOutput("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
    checkOutput("mid_rst_rx_data", 64'(rx_data), 64'd0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h3C, 1'b0, a0);
    waitDone();

    // Vector used for the settle-gap case (latency differs per build)
    applyStimulus(8'h81, 1'b0, a0);
    waitDone();

    // Randomised vectors and consumer delays
    $display("[TB] random vectors");
    for (int k = 0; k < 10; k++) begin
      vec = DIN_N'($urandom);
      rx_ready = 1'b0;
      applyStimulus(vec, 1'b0, a0);
      d = int'($urandom_range(0, 30));
      repeat (d) @(posedge clk);
      #1;
      rx_ready = 1'b1;
      waitDone();
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) failNow("scoreboard_not_empty");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
